counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
// - Receive-side monitor for the 4-bit enable counter's output (out[3:0]); observes its reset/enable/count each clk.
// - Runs a golden next-state model and flags any divergence; confirms obfuscated netlists behave as the plain counter.
// - Placed beside the counter on the same clock; observes only and never drives the counter.
// PARAMETERS
// - WIDTH         4  width of the observed count; wraps at 2**WIDTH.
// - LOCK_CNT      2  consecutive matching samples needed in SYNC before lock (>=1).
// - ERR_W         8  width of the saturating error counter.
// - STOP_ON_FAIL  1  1: first tracked mismatch parks in FAIL; 0: resync and keep checking.
// PORTS
// - clk        in   1      single clock, rising edge.
// - reset_n    in   1      asynchronous, active-low reset.
// - chk_en     in   1      checking enabled; low drops to UNSYNC.
// - clear      in   1      synchronous clear of state, err_count and fail.
// - obs_reset  in   1      counter's synchronous reset as seen at its input.
// - obs_en     in   1      counter's enable as seen at its input.
// - obs_count  in   WIDTH  counter output out[WIDTH-1:0].
// - locked     out  1      high in TRACK.
// - mismatch   out  1      one-cycle pulse on a tracked mismatch.
// - fail       out  1      sticky; set by the first tracked mismatch.
// - err_count  out  ERR_W  saturating count of tracked mismatches.
// - exp_count  out  WIDTH  model's expected value for the current cycle.
// BEHAVIOUR
// - Reset (reset_n=0, async): state=UNSYNC; locked=0, mismatch=0, fail=0, err_count=0, exp_count=0.
// - Model for each edge: nxt = obs_reset ? 0 : obs_en ? exp+1 (mod 2**WIDTH) : exp. obs_reset has priority over obs_en.
// - Each cycle compares obs_count to exp_count, then exp_count <= nxt. Compare result is visible one cycle after the sample.
// - UNSYNC: when chk_en=1, load exp from obs_count (apply the model to obs_count); good=1; go SYNC. No compare in this state.
// - SYNC: match -> good++; when good==LOCK_CNT go TRACK. Mismatch -> reload from obs_count, good=1, no error.
// - TRACK: locked=1. Match -> stay.
// - TRACK mismatch: mismatch=1 for 1 cycle; err_count++ (saturates at all-ones); fail<=1.
//   STOP_ON_FAIL=1: go FAIL. STOP_ON_FAIL=0: reload exp from obs_count and stay in TRACK.
// - FAIL: locked=0; compares frozen; exp_count held; stays until clear or chk_en=0.
// - chk_en=0 (any state): next state UNSYNC, locked=0. err_count and fail are retained.
// - clear=1: next state UNSYNC; err_count=0; fail=0. clear wins over a same-cycle mismatch; that mismatch is not counted.
// - Wrap: exp=2**WIDTH-1 with obs_en=1 gives exp=0. Wrap is not an error.
// - obs_reset while tracking is a legal event (exp becomes 0), not a mismatch.
// CONFIGURATION
// - CHK_TRACE_EN defined: adds outputs trace_valid (1), trace_exp and trace_obs (WIDTH each).
//   They capture exp/obs at the first tracked mismatch, hold until clear or reset_n, and all reset to 0.
// - CHK_TRACE_EN undefined: these ports and registers are absent; all other behaviour is identical.
// STRUCTURE
// - Package counter_chk_pkg: chk_state_t enum {UNSYNC, SYNC, TRACK, FAIL} and function next_count(cnt, rst, en).
// - Sub-module counter_ref_model: golden WIDTH-bit counter with load port. The checker FSM owns compare, lock and error logic.
// TESTING
// - Lock-in: chk_en=1, obs_en=1, count 0,1,2,... -> locked=1 on the 3rd cycle (LOCK_CNT=2); err_count stays 0.
// - Wrap: track through 14,15,0,1 with obs_en=1 -> no mismatch; exp_count=0 after 15.
// - Glitch: in TRACK, exp=5, inject obs_count=7 -> mismatch pulse 1 cycle, err_count=1, fail=1, state=FAIL, locked=0.
// - Reset event: in TRACK, obs_reset=1 with obs_en=1 at count 9 -> next obs_count=0 accepted, no mismatch.
// - Clear priority: clear=1 in the same cycle as a mismatch -> err_count=0, fail=0, state UNSYNC.
// - STOP_ON_FAIL=0: 300 injected mismatches -> err_count saturates at 255; locked stays 1.
//   With CHK_TRACE_EN, trace_exp/trace_obs hold the first pair.

Source files
------------

// File: rtl/counter_chk_pkg.sv
// Shared types and the plain-counter next-state rule used by the sequence checker.
package counter_chk_pkg;

  localparam int CNT_MAX_W = 16;

  typedef enum logic [1:0] {
    UNSYNC,
    SYNC,
    TRACK,
    FAIL
  } chk_state_t;

  // Callers zero-extend into CNT_MAX_W and truncate the result, which gives mod 2**WIDTH wrap.
  function automatic logic [CNT_MAX_W-1:0] next_count(input logic [CNT_MAX_W-1:0] cnt,
                                                      input logic rst,
                                                      input logic en);
    if (rst) begin
      return '0;
    end else if (en) begin
      return cnt + CNT_MAX_W'(1);
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Golden WIDTH-bit enable counter; can be re-seeded from the observed count or frozen.
module counter_ref_model
  import counter_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_rst,
  input  logic             step_en,
  output logic [WIDTH-1:0] count
);

  // A load applies this cycle's counter controls to the observed value, not just copies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!hold) begin
      count <= WIDTH'(next_count(CNT_MAX_W'(load ? load_val : count), step_rst, step_en));
    end
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side checker comparing an enable counter against a golden model.
// Define CHK_TRACE_EN to add the first-mismatch trace outputs.
module counter_seq_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int LOCK_CNT     = 2,
  parameter int ERR_W        = 8,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chk_en,
  input  logic             clear,
  input  logic             obs_reset,
  input  logic             obs_en,
  input  logic [WIDTH-1:0] obs_count,
  output logic             locked,
  output logic             mismatch,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] exp_count
`ifdef CHK_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [WIDTH-1:0] trace_exp,
  output logic [WIDTH-1:0] trace_obs
`endif
);

  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam bit STOP = (STOP_ON_FAIL != 0);

  chk_state_t        state;
  logic [GOOD_W-1:0] good;
  logic              live;
  logic              is_match;
  logic              tracked_miss;
  logic              ref_load;
  logic              ref_hold;

  // clear and a dropped chk_en both suppress any compare outcome for this cycle.
  always_comb begin
    live         = chk_en && !clear;
    is_match     = (obs_count == exp_count);
    tracked_miss = live && (state == TRACK) && !is_match;
    ref_hold     = (state == FAIL) || (tracked_miss && STOP);
    ref_load     = live && ((state == UNSYNC) || ((state == SYNC) && !is_match) ||
                            (tracked_miss && !STOP));
  end

  counter_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (ref_hold),
    .load     (ref_load),
    .load_val (obs_count),
    .step_rst (obs_reset),
    .step_en  (obs_en),
    .count    (exp_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNSYNC;
      good      <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      err_count <= '0;
    end else if (clear) begin
      state     <= UNSYNC;
      good      <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      err_count <= '0;
    end else if (!chk_en) begin
      state    <= UNSYNC;
      good     <= '0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        UNSYNC: begin
          state  <= SYNC;
          good   <= GOOD_W'(1);
          locked <= 1'b0;
        end
        SYNC: begin
          if (!is_match) begin
            good <= GOOD_W'(1);
          end else if (good >= LOCK_LAST) begin
            state  <= TRACK;
            locked <= 1'b1;
          end else begin
            good <= good + GOOD_W'(1);
          end
        end
        TRACK: begin
          if (!is_match) begin
            mismatch <= 1'b1;
            fail     <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (STOP) begin
              state  <= FAIL;
              locked <= 1'b0;
            end
          end
        end
        default: begin
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHK_TRACE_EN
  // fail is still low only on the very first tracked mismatch since the last clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      trace_exp   <= '0;
      trace_obs   <= '0;
    end else if (clear) begin
      trace_valid <= 1'b0;
      trace_exp   <= '0;
      trace_obs   <= '0;
    end else if (tracked_miss && !fail) begin
      trace_valid <= 1'b1;
      trace_exp   <= exp_count;
      trace_obs   <= obs_count;
    end
  end
`endif

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: two instances (stop-on-fail and resync) against a rule-level model.
// Compile with CHK_TRACE_EN defined to also check the trace outputs.
module tb_counter_seq_checker;

  localparam int LOCK_CNT = 2;
  localparam int MODV     = 16;
  localparam int ERR_MAX  = 255;
  localparam int P_IDLE   = 0;
  localparam int P_SYNC   = 1;
  localparam int P_TRACK  = 2;
  localparam int P_HALT   = 3;

  typedef struct {
    int phase;
    int exp;
    int run;
    int err;
    bit fail;
    bit mis;
    bit lock;
    bit tv;
    int te;
    int to;
  } mdl_t;

  typedef struct {
    bit chk;
    bit clr;
    bit rst;
    bit en;
    int obs;
    bit lock;
    bit mis;
    int err;
    bit fail;
    int expc;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       chk_en;
  logic       clear;
  logic       obs_reset;
  logic       obs_en;
  logic [3:0] obs_count;

  logic       a_locked, a_mismatch, a_fail;
  logic [7:0] a_err;
  logic [3:0] a_exp;
  logic       b_locked, b_mismatch, b_fail;
  logic [7:0] b_err;
  logic [3:0] b_exp;
`ifdef CHK_TRACE_EN
  logic       a_tv, b_tv;
  logic [3:0] a_te, a_to, b_te, b_to;
`endif

  int   n_cmp;
  int   n_bad;
  mdl_t ma;
  mdl_t mb;
  vec_t tbl[$];

  counter_seq_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(8), .STOP_ON_FAIL(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .clear(clear),
    .obs_reset(obs_reset), .obs_en(obs_en), .obs_count(obs_count),
    .locked(a_locked), .mismatch(a_mismatch), .fail(a_fail),
    .err_count(a_err), .exp_count(a_exp)
`ifdef CHK_TRACE_EN
    , .trace_valid(a_tv), .trace_exp(a_te), .trace_obs(a_to)
`endif
  );

  counter_seq_checker #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(8), .STOP_ON_FAIL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .clear(clear),
    .obs_reset(obs_reset), .obs_en(obs_en), .obs_count(obs_count),
    .locked(b_locked), .mismatch(b_mismatch), .fail(b_fail),
    .err_count(b_err), .exp_count(b_exp)
`ifdef CHK_TRACE_EN
    , .trace_valid(b_tv), .trace_exp(b_te), .trace_obs(b_to)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int advance(int c, bit r, bit e);
    if (r) return 0;
    if (e) return (c + 1) % MODV;
    return c;
  endfunction

  function automatic mdl_t model_reset();
    mdl_t m;
    m.phase = P_IDLE; m.exp = 0; m.run = 0; m.err = 0; m.fail = 0;
    m.mis = 0; m.lock = 0; m.tv = 0; m.te = 0; m.to = 0;
    return m;
  endfunction

  // Checker behaviour stated as rules: what the next expectation is, then how lock/errors evolve.
  function automatic mdl_t model_step(mdl_t m, bit stop, bit chk, bit clr, bit orst, bit oen, int obs);
    mdl_t n;
    bit   hit;
    bit   live;
    n    = m;
    n.mis = 0;
    hit  = (obs == m.exp);
    live = chk && !clr;
    if (m.phase == P_HALT || (live && m.phase == P_TRACK && !hit && stop))
      n.exp = m.exp;
    else if (live && (m.phase == P_IDLE || !hit))
      n.exp = advance(obs, orst, oen);
    else
      n.exp = advance(m.exp, orst, oen);
    if (live && m.phase == P_TRACK && !hit && !m.fail) begin
      n.tv = 1; n.te = m.exp; n.to = obs;
    end
    if (clr) begin
      n.phase = P_IDLE; n.lock = 0; n.err = 0; n.fail = 0; n.run = 0;
      n.tv = 0; n.te = 0; n.to = 0;
    end else if (!chk) begin
      n.phase = P_IDLE; n.lock = 0; n.run = 0;
    end else if (m.phase == P_IDLE) begin
      n.phase = P_SYNC; n.run = 1; n.lock = 0;
    end else if (m.phase == P_SYNC) begin
      if (hit) begin
        n.run = m.run + 1;
        if (n.run >= LOCK_CNT) begin
          n.phase = P_TRACK; n.lock = 1;
        end
      end else begin
        n.run = 1;
      end
    end else if (m.phase == P_TRACK && !hit) begin
      n.mis  = 1;
      n.fail = 1;
      n.err  = (m.err < ERR_MAX) ? m.err + 1 : ERR_MAX;
      if (stop) begin
        n.phase = P_HALT; n.lock = 0;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("a_locked", a_locked, ma.lock);
    checkOutput("a_mismatch", a_mismatch, ma.mis);
    checkOutput("a_fail", a_fail, ma.fail);
    checkOutput("a_err", a_err, ma.err);
    checkOutput("a_exp", a_exp, ma.exp);
    checkOutput("b_locked", b_locked, mb.lock);
    checkOutput("b_mismatch", b_mismatch, mb.mis);
    checkOutput("b_fail", b_fail, mb.fail);
    checkOutput("b_err", b_err, mb.err);
    checkOutput("b_exp", b_exp, mb.exp);
`ifdef CHK_TRACE_EN
    checkOutput("a_trace_valid", a_tv, ma.tv);
    checkOutput("a_trace_exp", a_te, ma.te);
    checkOutput("a_trace_obs", a_to, ma.to);
    checkOutput("b_trace_valid", b_tv, mb.tv);
    checkOutput("b_trace_exp", b_te, mb.te);
    checkOutput("b_trace_obs", b_to, mb.to);
`endif
  endtask

  // Drive one cycle, advance both models across the edge, then compare just after it.
  task automatic applyStimulus(bit chk, bit clr, bit orst, bit oen, int obs);
    chk_en    = chk;
    clear     = clr;
    obs_reset = orst;
    obs_en    = oen;
    obs_count = 4'(obs);
    @(posedge clk);
    ma = model_step(ma, 1'b1, chk, clr, orst, oen, obs);
    mb = model_step(mb, 1'b0, chk, clr, orst, oen, obs);
    #1;
    compareAll();
  endtask

  function automatic vec_t mk(bit chk, bit clr, bit rst, bit en, int obs,
                              bit lock, bit mis, int err, bit fail, int expc);
    vec_t v;
    v.chk = chk; v.clr = clr; v.rst = rst; v.en = en; v.obs = obs;
    v.lock = lock; v.mis = mis; v.err = err; v.fail = fail; v.expc = expc;
    return v;
  endfunction

  initial begin
    int plant;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0; chk_en = 1'b0; clear = 1'b0;
    obs_reset = 1'b0; obs_en = 1'b0; obs_count = 4'd0;
    ma = model_reset();
    mb = model_reset();

    // Lock-in, wrap, legal reset event, hold, glitch into FAIL, then clear.
    for (int i = 0; i < 18; i++)
      tbl.push_back(mk(1, 0, 0, 1, i % MODV, i >= 1, 0, 0, 0, (i + 1) % MODV));
    tbl.push_back(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 1, 1, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 1, 0, 1, 7, 0, 0, 0, 0, 2));

    #12;
    compareAll();
    checkOutput("reset_locked", a_locked, 0);
    checkOutput("reset_exp", a_exp, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].chk, tbl[i].clr, tbl[i].rst, tbl[i].en, tbl[i].obs);
      checkOutput($sformatf("vec%0d_locked", i), a_locked, tbl[i].lock);
      checkOutput($sformatf("vec%0d_mismatch", i), a_mismatch, tbl[i].mis);
      checkOutput($sformatf("vec%0d_err", i), a_err, tbl[i].err);
      checkOutput($sformatf("vec%0d_fail", i), a_fail, tbl[i].fail);
      checkOutput($sformatf("vec%0d_exp", i), a_exp, tbl[i].expc);
    end

    // Glitch: expecting 5, observe 7.
    applyStimulus(1, 0, 0, 1, 3);
    applyStimulus(1, 0, 0, 1, 4);
    checkOutput("glitch_pre_exp", a_exp, 5);
    applyStimulus(1, 0, 0, 1, 7);
    checkOutput("glitch_mismatch", a_mismatch, 1);
    checkOutput("glitch_err", a_err, 1);
    checkOutput("glitch_fail", a_fail, 1);
    checkOutput("glitch_locked", a_locked, 0);
    checkOutput("glitch_b_locked", b_locked, 1);
    applyStimulus(1, 0, 0, 1, 8);
    checkOutput("glitch_pulse_end", a_mismatch, 0);

    // Reset event while tracking at count 9.
    applyStimulus(0, 0, 0, 1, 9);
    applyStimulus(1, 0, 0, 1, 7);
    applyStimulus(1, 0, 0, 1, 8);
    applyStimulus(1, 0, 1, 1, 9);
    checkOutput("rstev_exp", a_exp, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("rstev_mismatch", a_mismatch, 0);
    checkOutput("rstev_err_kept", a_err, 1);
    checkOutput("rstev_locked", a_locked, 1);

    // Clear in the same cycle as a tracked mismatch.
    applyStimulus(1, 1, 0, 1, 6);
    checkOutput("clrpri_err", a_err, 0);
    checkOutput("clrpri_fail", a_fail, 0);
    checkOutput("clrpri_mismatch", a_mismatch, 0);
    checkOutput("clrpri_locked", a_locked, 0);

    // 300 tracked mismatches: resync instance saturates and stays locked.
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    for (int i = 0; i < 300; i++)
      applyStimulus(1, 0, 0, 1, (mb.exp + 3) % MODV);
    checkOutput("sat_b_err", b_err, 255);
    checkOutput("sat_b_locked", b_locked, 1);
    checkOutput("sat_a_err", a_err, 1);
`ifdef CHK_TRACE_EN
    checkOutput("sat_b_trace_exp", b_te, 2);
    checkOutput("sat_b_trace_obs", b_to, 5);
    checkOutput("sat_a_trace_obs", a_to, 5);
`endif
    applyStimulus(1, 1, 0, 0, 0);

    // Random counter traffic with occasional glitches, drops of chk_en and clears.
    plant = 0;
    for (int i = 0; i < 2000; i++) begin
      bit r, e, c, k;
      int o;
      r = ($urandom % 20) == 0;
      e = ($urandom % 4) != 0;
      c = ($urandom % 50) != 0;
      k = ($urandom % 100) == 0;
      o = (($urandom % 30) == 0) ? int'($urandom % MODV) : plant;
      applyStimulus(c, k, r, e, o);
      plant = advance(plant, r, e);
    end

    // Asynchronous reset between edges.
    #3;
    reset_n = 1'b0;
    #1;
    ma = model_reset();
    mb = model_reset();
    compareAll();
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
